// File: rtl/pan_line_multi.sv
// Multi-lane baking-pan conveyor plant model with a shared,
// round-robin arbitrated fill supply and per-lane pan counters.
module pan_line_multi #(
  parameter int          LANES       = 2,
  parameter int          SLOTS       = 4,
  parameter int          PAN_PERIOD  = 10,
  parameter int          ANIM_PERIOD = 3,
  parameter int          FILL_STEP   = 1500,
  parameter int          FULL_LEVEL  = 8192,
  parameter int          SPILL_LEVEL = 12288,
  parameter logic [15:0] PRBS_SEED   = 16'h1235
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [LANES-1:0]       X_dispenser,
  input  logic [LANES-1:0]       X_pan_conveyor,
  input  logic                   S_pressure_high,
  input  logic [15:0]            S_water,
  output logic [LANES-1:0]       Y_pan,
  output logic [LANES-1:0]       Y_pan_full,
  output logic [LANES-1:0]       Y_spill,
  output logic [16*LANES-1:0]    S_pan_weight,
  output logic [SLOTS*LANES-1:0] S_pans,
  output logic [7*LANES-1:0]     S_conveyor,
  output logic [16*LANES-1:0]    S_good,
  output logic [16*LANES-1:0]    S_reject
);

  localparam int RW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [15:0] FULL_W  = 16'(FULL_LEVEL);
  localparam logic [15:0] SPILL_W = 16'(SPILL_LEVEL);
  localparam logic [16:0] STEP_W  = 17'(FILL_STEP);

  logic [15:0]            pan_cnt_q, pan_cnt_d;
  logic [15:0]            anim_cnt_q, anim_cnt_d;
  logic [15:0]            prbs_q, prbs_d;
  logic [RW-1:0]          rr_q, rr_d;
  logic [SLOTS*LANES-1:0] pans_q, pans_d;
  logic [16*LANES-1:0]    weight_q, weight_d;
  logic [LANES-1:0]       full_q, full_d;
  logic [LANES-1:0]       spill_q, spill_d;
  logic [7*LANES-1:0]     conv_q, conv_d;
  logic [16*LANES-1:0]    good_q, good_d;
  logic [16*LANES-1:0]    rej_q, rej_d;

  logic             pan_step;
  logic             anim_step;
  logic [LANES-1:0] req;
  logic [LANES-1:0] shift;
  logic             gnt_found;
  logic             gnt_vld;
  logic [RW-1:0]    gnt_idx;
  logic [16:0]      sum;
  logic [15:0]      wnext;

  always_comb begin
    pan_cnt_d  = pan_cnt_q;
    anim_cnt_d = anim_cnt_q;
    prbs_d     = prbs_q;
    rr_d       = rr_q;
    pans_d     = pans_q;
    weight_d   = weight_q;
    full_d     = full_q;
    spill_d    = spill_q;
    conv_d     = conv_q;
    good_d     = good_q;
    rej_d      = rej_q;
    req        = '0;
    shift      = '0;
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    sum        = '0;
    wnext      = '0;

    pan_step  = en && (pan_cnt_q == 16'(PAN_PERIOD - 1));
    anim_step = en && (anim_cnt_q == 16'(ANIM_PERIOD - 1));

    if (en) begin
      pan_cnt_d  = pan_step ? 16'd0 : pan_cnt_q + 16'd1;
      anim_cnt_d = anim_step ? 16'd0 : anim_cnt_q + 16'd1;
      prbs_d     = {1'b0, prbs_q[15:1]}
                 ^ (prbs_q[0] ? 16'hA001 : 16'h0000);
    end

    for (int l = 0; l < LANES; l++) begin
      req[l] = pans_q[SLOTS*l+SLOTS-1] & X_dispenser[l]
             & ~spill_q[l] & S_pressure_high
             & (S_water != 16'd0);
      shift[l] = pan_step & X_pan_conveyor[l];
    end

    for (int k = 0; k < LANES; k++) begin
      if (!gnt_found && req[(int'(rr_q) + k) % LANES]) begin
        gnt_found = 1'b1;
        gnt_idx   = RW'((int'(rr_q) + k) % LANES);
      end
    end
    gnt_vld = gnt_found & en;

    for (int l = 0; l < LANES; l++) begin
      sum   = {1'b0, weight_q[16*l +: 16]} + STEP_W;
      wnext = sum[16] ? 16'hFFFF : sum[15:0];
      if (shift[l]) begin
        // the departing pan is judged on its final weight and flag
        if (pans_q[SLOTS*l+SLOTS-1]) begin
          if (weight_q[16*l +: 16] >= FULL_W && !spill_q[l])
            good_d[16*l +: 16] = good_q[16*l +: 16] + 16'd1;
          else
            rej_d[16*l +: 16] = rej_q[16*l +: 16] + 16'd1;
        end
        for (int s = 1; s < SLOTS; s++)
          pans_d[SLOTS*l+s] = pans_q[SLOTS*l+s-1];
        pans_d[SLOTS*l] = ~pans_q[SLOTS*l]
                        & (prbs_q[2*l +: 2] == 2'b00);
        weight_d[16*l +: 16] = 16'd0;
        full_d[l]            = 1'b0;
        spill_d[l]           = 1'b0;
      end else if (gnt_vld && gnt_idx == RW'(l)) begin
        weight_d[16*l +: 16] = wnext;
        full_d[l]            = wnext >= FULL_W;
        spill_d[l]           = spill_q[l] | (wnext >= SPILL_W);
      end
      if (anim_step && X_pan_conveyor[l])
        conv_d[7*l +: 7] = {conv_q[7*l +: 6],
                            conv_q[7*l +: 2] == 2'b00};
    end

    // a grant lost to a same-cycle shift leaves the pointer alone
    if (gnt_vld && !shift[gnt_idx])
      rr_d = RW'((int'(gnt_idx) + 1) % LANES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pan_cnt_q  <= '0;
      anim_cnt_q <= '0;
      prbs_q     <= PRBS_SEED;
      rr_q       <= '0;
      pans_q     <= '0;
      weight_q   <= '0;
      full_q     <= '0;
      spill_q    <= '0;
      conv_q     <= '0;
      good_q     <= '0;
      rej_q      <= '0;
    end else begin
      pan_cnt_q  <= pan_cnt_d;
      anim_cnt_q <= anim_cnt_d;
      prbs_q     <= prbs_d;
      rr_q       <= rr_d;
      pans_q     <= pans_d;
      weight_q   <= weight_d;
      full_q     <= full_d;
      spill_q    <= spill_d;
      conv_q     <= conv_d;
      good_q     <= good_d;
      rej_q      <= rej_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_pan
    assign Y_pan[l] = pans_q[SLOTS*l+SLOTS-1];
  end

  assign Y_pan_full   = full_q;
  assign Y_spill      = spill_q;
  assign S_pan_weight = weight_q;
  assign S_pans       = pans_q;
  assign S_conveyor   = conv_q;
  assign S_good       = good_q;
  assign S_reject     = rej_q;

endmodule
